// File: rtl/wash_seq.sv
// Wash-cycle sequencer: checks and deducts the mode price on start, then
// steps through WASH, RINSE and SPIN on a 1 s tick with pause/resume.
// It reports phase, remaining seconds and balance to the display and LEDs.
module wash_seq #(
    parameter int TICK_DIV  = 100000000,
    parameter int DONE_HOLD = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bal_ld,
    input  logic [9:0] bal_in,
    input  logic [1:0] mode,
    input  logic       start,
    input  logic       pause,
    output logic [2:0] phase,
    output logic [7:0] remain,
    output logic [9:0] bal_out,
    output logic       busy,
    output logic       paused,
    output logic       done,
    output logic       err
);

    localparam int TCW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WASH, S_RINSE, S_SPIN, S_PAUSE, S_DONE
    } state_t;

    state_t         state_q, state_d;
    state_t         resume_q, resume_d;
    logic [1:0]     mode_q, mode_d;
    logic [9:0]     bal_q, bal_d;
    logic [TCW-1:0] tick_q, tick_d;
    logic [7:0]     pcnt_q, pcnt_d;
    logic [7:0]     rem_q, rem_d;
    logic           err_d;
    logic [2:0]     phase_d;
    state_t         shown;
    state_t         nxt;

    // Duration in seconds of one phase for a given mode.
    function automatic logic [7:0] dur(input logic [1:0] m, input state_t p);
        logic [7:0] w, r, s;
        case (m)
            2'd0:    begin w = 8'd3; r = 8'd2; s = 8'd2; end
            2'd1:    begin w = 8'd6; r = 8'd4; s = 8'd3; end
            2'd2:    begin w = 8'd9; r = 8'd6; s = 8'd4; end
            default: begin w = 8'd0; r = 8'd0; s = 8'd5; end
        endcase
        case (p)
            S_WASH:  return w;
            S_RINSE: return r;
            S_SPIN:  return s;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic [9:0] price(input logic [1:0] m);
        case (m)
            2'd0:    return 10'd5;
            2'd1:    return 10'd8;
            2'd2:    return 10'd12;
            default: return 10'd3;
        endcase
    endfunction

    // Zero-length phases are skipped so they never appear on the phase output.
    function automatic state_t next_phase(input logic [1:0] m, input state_t p);
        case (p)
            S_IDLE:  return (dur(m, S_WASH) != 8'd0) ? S_WASH :
                            (dur(m, S_RINSE) != 8'd0) ? S_RINSE : S_SPIN;
            S_WASH:  return (dur(m, S_RINSE) != 8'd0) ? S_RINSE : S_SPIN;
            S_RINSE: return S_SPIN;
            default: return S_DONE;
        endcase
    endfunction

    // Next-state, counter and balance computation.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d  = state_q;
        resume_d = resume_q;
        mode_d   = mode_q;
        bal_d    = bal_q;
        tick_d   = tick_q;
        pcnt_d   = pcnt_q;
        rem_d    = rem_q;
        err_d    = 1'b0;
        nxt      = S_IDLE;

        case (state_q)
            S_IDLE: begin
                // start takes priority; a simultaneous load is dropped.
                if (start) begin
                    if (bal_q >= price(mode)) begin
                        nxt     = next_phase(mode, S_IDLE);
                        state_d = nxt;
                        mode_d  = mode;
                        bal_d   = bal_q - price(mode);
                        rem_d   = dur(mode, S_WASH) + dur(mode, S_RINSE) + dur(mode, S_SPIN);
                        pcnt_d  = dur(mode, nxt);
                        tick_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bal_ld) begin
                    bal_d = bal_in;
                end
            end
            S_WASH, S_RINSE, S_SPIN: begin
                // pause beats start and freezes the tick counter on this cycle.
                if (pause) begin
                    state_d  = S_PAUSE;
                    resume_d = state_q;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    rem_d  = rem_q - 8'd1;
                    if (pcnt_q <= 8'd1) begin
                        nxt     = next_phase(mode_q, state_q);
                        state_d = nxt;
                        pcnt_d  = (nxt == S_DONE) ? 8'(DONE_HOLD) : dur(mode_q, nxt);
                    end else begin
                        pcnt_d = pcnt_q - 8'd1;
                    end
                end else begin
                    tick_d = tick_q + TCW'(1);
                end
            end
            S_PAUSE: begin
                if (pause) begin
                    state_d = resume_q;
                end
            end
            S_DONE: begin
                // The phase counter doubles as the DONE hold timer.
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (pcnt_q <= 8'd1) begin
                        state_d = S_IDLE;
                        pcnt_d  = 8'd0;
                    end else begin
                        pcnt_d = pcnt_q - 8'd1;
                    end
                end else begin
                    tick_d = tick_q + TCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        shown = (state_d == S_PAUSE) ? resume_d : state_d;
        case (shown)
            S_WASH:  phase_d = 3'b001;
            S_RINSE: phase_d = 3'b010;
            S_SPIN:  phase_d = 3'b100;
            default: phase_d = 3'b000;
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: reset is asynchronous; the whole block uses non-blocking assignments.
        if (!rst) begin
            state_q  <= S_IDLE;
            resume_q <= S_IDLE;
            mode_q   <= 2'd0;
            bal_q    <= 10'd0;
            tick_q   <= '0;
            pcnt_q   <= 8'd0;
            rem_q    <= 8'd0;
            phase    <= 3'b000;
            busy     <= 1'b0;
            paused   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            mode_q   <= mode_d;
            bal_q    <= bal_d;
            tick_q   <= tick_d;
            pcnt_q   <= pcnt_d;
            rem_q    <= rem_d;
            phase    <= phase_d;
            busy     <= (state_d == S_WASH) || (state_d == S_RINSE) ||
                        (state_d == S_SPIN) || (state_d == S_PAUSE);
            paused   <= (state_d == S_PAUSE);
            done     <= (state_d == S_DONE);
            err      <= err_d;
        end
    end

    assign remain  = rem_q;
    assign bal_out = bal_q;

endmodule

// File: tb/tb_wash_seq.sv
// Self-checking bench for wash_seq with TICK_DIV=10 and DONE_HOLD=3.
module tb_wash_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bal_ld = 1'b0;
    logic [9:0] bal_in = '0;
    logic [1:0] mode = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [2:0] phase;
    logic [7:0] remain;
    logic [9:0] bal_out;
    logic       busy, paused, done, err;

    int checks = 0;
    int errors = 0;

    wash_seq #(.TICK_DIV(10), .DONE_HOLD(3)) dut (
        .clk(clk), .rst(rst), .bal_ld(bal_ld), .bal_in(bal_in), .mode(mode),
        .start(start), .pause(pause), .phase(phase), .remain(remain),
        .bal_out(bal_out), .busy(busy), .paused(paused), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bal; int md;
        int e_err; int e_bal; int e_phase; int e_remain; int e_busy;
    } vec_t;

    typedef struct {
        int e_err; int e_bal; int e_phase; int e_remain; int e_busy;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        step();
    endtask

    task automatic load(input int v);
        bal_ld = 1'b1; bal_in = 10'(v);
        step();
        bal_ld = 1'b0;
    endtask

    function automatic int cur(input int sel);
        case (sel)
            0: return int'(phase);
            1: return int'(done);
            2: return int'(remain);
            default: return int'(busy);
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int val, input int budget, output int n);
        n = 0;
        while (cur(sel) != val && n < budget) begin
            step();
            n++;
        end
    endtask

    initial begin
        vec_t vecs[10];
        exp_t e;
        int n;
        logic saw_wr;

        vecs[0] = '{5,   0, 0, 0,   1, 7,  1};
        vecs[1] = '{4,   0, 1, 4,   0, 0,  0};
        vecs[2] = '{8,   1, 0, 0,   1, 13, 1};
        vecs[3] = '{7,   1, 1, 7,   0, 0,  0};
        vecs[4] = '{12,  2, 0, 0,   1, 19, 1};
        vecs[5] = '{11,  2, 1, 11,  0, 0,  0};
        vecs[6] = '{3,   3, 0, 0,   4, 5,  1};
        vecs[7] = '{2,   3, 1, 2,   0, 0,  0};
        vecs[8] = '{999, 2, 0, 987, 1, 19, 1};
        vecs[9] = '{0,   3, 1, 0,   0, 0,  0};

        // Reset state.
        #3;
        check("rst_phase", int'(phase), 0);
        check("rst_remain", int'(remain), 0);
        check("rst_bal", int'(bal_out), 0);
        check("rst_flags", int'({busy, paused, done, err}), 0);
        rst = 1'b1;
        step();

        // Price check table, every mode at and just below its price.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            load(vecs[i].bal);
            check($sformatf("v%0d_load", i), int'(bal_out), vecs[i].bal);
            mode = 2'(vecs[i].md); start = 1'b1;
            sb.push_back('{vecs[i].e_err, vecs[i].e_bal, vecs[i].e_phase,
                           vecs[i].e_remain, vecs[i].e_busy});
            step();
            start = 1'b0;
            e = sb.pop_front();
            check($sformatf("v%0d_err", i), int'(err), e.e_err);
            check($sformatf("v%0d_bal", i), int'(bal_out), e.e_bal);
            check($sformatf("v%0d_phase", i), int'(phase), e.e_phase);
            check($sformatf("v%0d_remain", i), int'(remain), e.e_remain);
            check($sformatf("v%0d_busy", i), int'(busy), e.e_busy);
        end

        // Full mode-1 cycle timing.
        do_reset();
        load(20);
        mode = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        check("m1_bal", int'(bal_out), 12);
        check("m1_phase", int'(phase), 1);
        check("m1_remain", int'(remain), 13);
        wait_sig(0, 2, 200, n);
        check("m1_rinse_cyc", n, 60);
        check("m1_rinse_rem", int'(remain), 7);
        wait_sig(0, 4, 200, n);
        check("m1_spin_cyc", n, 40);
        check("m1_spin_rem", int'(remain), 3);
        wait_sig(1, 1, 200, n);
        check("m1_done_cyc", n, 30);
        check("m1_done_rem", int'(remain), 0);
        check("m1_done_phase", int'(phase), 0);
        check("m1_done_busy", int'(busy), 0);
        wait_sig(1, 0, 200, n);
        check("m1_hold_cyc", n, 30);
        check("m1_idle_busy", int'(busy), 0);

        // Rejected start then accepted start.
        do_reset();
        load(4);
        mode = 2'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("rej_err", int'(err), 1);
        check("rej_bal", int'(bal_out), 4);
        check("rej_busy", int'(busy), 0);
        step();
        check("rej_err_pulse", int'(err), 0);
        load(5);
        start = 1'b1;
        step();
        start = 1'b0;
        check("acc_bal", int'(bal_out), 0);
        check("acc_busy", int'(busy), 1);
        check("acc_err", int'(err), 0);

        // Spin-only mode never shows WASH or RINSE.
        do_reset();
        load(3);
        mode = 2'd3; start = 1'b1;
        step();
        start = 1'b0;
        check("m3_phase", int'(phase), 4);
        check("m3_remain", int'(remain), 5);
        check("m3_bal", int'(bal_out), 0);
        saw_wr = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            step();
            n++;
            if (phase[1:0] != 2'b00) saw_wr = 1'b1;
        end
        check("m3_no_wr", int'(saw_wr), 0);
        check("m3_done_cyc", n, 50);

        // Pause mid-tick freezes everything; resume continues the tick count.
        do_reset();
        load(5);
        mode = 2'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (24) step();
        check("p_pre_rem", int'(remain), 5);
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("p_paused", int'(paused), 1);
        repeat (50) step();
        check("p_frz_rem", int'(remain), 5);
        check("p_frz_phase", int'(phase), 1);
        check("p_frz_paused", int'(paused), 1);
        check("p_frz_busy", int'(busy), 1);
        pause = 1'b1;
        step();
        pause = 1'b0;
        check("p_resumed", int'(paused), 0);
        wait_sig(2, 4, 50, n);
        check("p_next_tick", n, 6);

        // start+pause in WASH, bal_ld in WASH.
        do_reset();
        load(30);
        mode = 2'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("sp_bal", int'(bal_out), 25);
        load(100);
        check("sp_ld_ignored", int'(bal_out), 25);
        start = 1'b1; pause = 1'b1;
        step();
        start = 1'b0; pause = 1'b0;
        check("sp_paused", int'(paused), 1);
        check("sp_bal2", int'(bal_out), 25);

        // Asynchronous reset during RINSE.
        do_reset();
        load(30);
        mode = 2'd1; start = 1'b1;
        step();
        start = 1'b0;
        wait_sig(0, 2, 200, n);
        check("ar_in_rinse", int'(phase), 2);
        #2 rst = 1'b0;
        #1;
        check("ar_phase", int'(phase), 0);
        check("ar_remain", int'(remain), 0);
        check("ar_bal", int'(bal_out), 0);
        check("ar_flags", int'({busy, paused, done, err}), 0);
        rst = 1'b1;
        step();
        mode = 2'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("ar_err", int'(err), 1);
        check("ar_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
